// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with an auto-scan mode that
// walks the asserted bit through every position, holding each for DWELL cycles.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | en low or after reset; out deasserted, active = 0
//   S_DIRECT | direct decode; out = onehot(cur) once a load has been taken
//   S_SCAN   | auto scan; cur advances every DWELL cycles, wraps to 0
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] cur,
  output logic             active,
  output logic             wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] CUR_LAST = SEL_W'(OUT_W - 1);
  // XOR mask: applying it to a one-hot value gives the output polarity,
  // and on its own it is the idle pattern.
  localparam logic [OUT_W-1:0] IDLE_OUT = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    return {{(OUT_W-1){1'b0}}, 1'b1} << idx;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cur    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      wrap   <= 1'b0;
      out    <= IDLE_OUT;
    end else begin
      wrap <= 1'b0;
      if (!en) begin
        state  <= S_IDLE;
        cnt    <= '0;
        active <= 1'b0;
        out    <= IDLE_OUT;
      end else if (!mode) begin
        state <= S_DIRECT;
        cnt   <= '0;
        if (load) begin
          cur    <= sel;
          active <= 1'b1;
          out    <= onehot(sel) ^ IDLE_OUT;
        end else if (state != S_DIRECT) begin
          active <= 1'b0;
          out    <= IDLE_OUT;
        end
      end else begin
        state  <= S_SCAN;
        active <= 1'b1;
        if (state != S_SCAN) begin
          cur <= '0;
          cnt <= '0;
          out <= onehot('0) ^ IDLE_OUT;
        end else if (cnt == CNT_LAST) begin
          cnt  <= '0;
          cur  <= cur + 1'b1;
          out  <= onehot(cur + 1'b1) ^ IDLE_OUT;
          wrap <= (cur == CUR_LAST);
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three parameterisations driven by shared directed and
// random stimulus, checked against an elapsed-time reference model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [2:0] sel = '0;

  logic [7:0] out_a, out_b;
  logic [3:0] out_c;
  logic [2:0] cur_a, cur_b;
  logic [1:0] cur_c;
  logic       active_a, active_b, active_c;
  logic       wrap_a, wrap_b, wrap_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .sel(sel),
    .out(out_a), .cur(cur_a), .active(active_a), .wrap(wrap_a));

  decoder_scan #(.SEL_W(3), .DWELL(3), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .sel(sel),
    .out(out_b), .cur(cur_b), .active(active_b), .wrap(wrap_b));

  decoder_scan #(.SEL_W(2), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .sel(sel[1:0]),
    .out(out_c), .cur(cur_c), .active(active_c), .wrap(wrap_c));

  // Reference model: 0 idle, 1 direct, 2 scan; scan position derived from
  // the number of cycles elapsed since scan entry.
  int p_sw[3] = '{3, 3, 2};
  int p_dw[3] = '{4, 3, 1};
  bit p_al[3] = '{1'b0, 1'b1, 1'b0};
  int m_st[3];
  int m_t[3];
  int m_cur[3];
  bit m_act[3];
  bit m_wrap[3];

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int ow;
      ow = 1 << p_sw[k];
      m_wrap[k] = 1'b0;
      if (reset) begin
        m_st[k] = 0; m_cur[k] = 0; m_act[k] = 1'b0;
      end else if (!en) begin
        m_st[k] = 0; m_act[k] = 1'b0;
      end else if (!mode) begin
        if (load) begin
          m_cur[k] = int'(sel) % ow;
          m_act[k] = 1'b1;
        end else if (m_st[k] != 1) begin
          m_act[k] = 1'b0;
        end
        m_st[k] = 1;
      end else begin
        if (m_st[k] != 2) m_t[k] = 0;
        else m_t[k] = m_t[k] + 1;
        m_st[k] = 2;
        m_cur[k] = (m_t[k] / p_dw[k]) % ow;
        m_act[k] = 1'b1;
        m_wrap[k] = (m_t[k] > 0) && (m_t[k] % (p_dw[k] * ow) == 0);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_out(input int k);
    logic [31:0] e;
    logic [31:0] mask;
    mask = (32'd1 << (1 << p_sw[k])) - 1;
    e = m_act[k] ? (32'd1 << m_cur[k]) : 32'd0;
    if (p_al[k]) e = ~e & mask;
    return e;
  endfunction

  task automatic check_all();
    chk("a_out", {24'd0, out_a}, exp_out(0));
    chk("a_cur", {29'd0, cur_a}, m_cur[0]);
    chk("a_active", {31'd0, active_a}, {31'd0, m_act[0]});
    chk("a_wrap", {31'd0, wrap_a}, {31'd0, m_wrap[0]});
    chk("b_out", {24'd0, out_b}, exp_out(1));
    chk("b_cur", {29'd0, cur_b}, m_cur[1]);
    chk("b_active", {31'd0, active_b}, {31'd0, m_act[1]});
    chk("b_wrap", {31'd0, wrap_b}, {31'd0, m_wrap[1]});
    chk("c_out", {28'd0, out_c}, exp_out(2));
    chk("c_cur", {30'd0, cur_c}, m_cur[2]);
    chk("c_active", {31'd0, active_c}, {31'd0, m_act[2]});
    chk("c_wrap", {31'd0, wrap_c}, {31'd0, m_wrap[2]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_t[k] = 0; m_cur[k] = 0; m_act[k] = 1'b0; m_wrap[k] = 1'b0;
    end

    // reset held two cycles, then idle
    reset = 1'b1;
    step(); step();
    chk("rst_out_a", {24'd0, out_a}, 32'h00);
    chk("rst_out_b", {24'd0, out_b}, 32'hFF);
    reset = 1'b0;
    step(); step();
    chk("idle_out_b", {24'd0, out_b}, 32'hFF);

    // direct sweep
    en = 1'b1; mode = 1'b0; load = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step();
      chk("sweep_out_a", {24'd0, out_a}, 32'd1 << s);
    end
    for (int s = 0; s < 6; s++) begin
      sel = 3'(s);
      step();
    end
    load = 1'b0; sel = 3'd1;
    step(); step(); step();
    chk("hold_out_a", {24'd0, out_a}, 32'h20);
    chk("hold_cur_a", {29'd0, cur_a}, 32'd5);

    // scan, DWELL=4 on dut_a; load during scan must be ignored
    mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin load = 1'b1; sel = 3'd6; end
      if (i == 14) load = 1'b0;
      step();
      chk("scan_out_a", {24'd0, out_a}, 32'd1 << (((i - 1) / 4) % 8));
      chk("scan_wrap_a", {31'd0, wrap_a}, (i == 33) ? 32'd1 : 32'd0);
    end

    // interruption: leave scan at cur=3
    for (int n = 0; n < 64 && m_cur[0] != 3; n++) step();
    chk("at_cur3", {29'd0, cur_a}, 32'd3);
    mode = 1'b0;
    step();
    chk("to_direct_out", {24'd0, out_a}, 32'h00);
    chk("to_direct_active", {31'd0, active_a}, 32'd0);
    load = 1'b1; sel = 3'd2;
    step();
    chk("direct_load2", {24'd0, out_a}, 32'h04);
    load = 1'b0; mode = 1'b1;
    step();
    chk("rescan_out", {24'd0, out_a}, 32'h01);
    for (int n = 0; n < 5; n++) step();
    en = 1'b0;
    step();
    chk("dis_out", {24'd0, out_a}, 32'h00);
    chk("dis_cur_kept", {29'd0, cur_a}, 32'd1);

    // SCAN->DIRECT with load on the switching cycle
    en = 1'b1; mode = 1'b1;
    step(); step();
    mode = 1'b0; load = 1'b1; sel = 3'd7;
    step();
    chk("switch_load", {24'd0, out_a}, 32'h80);
    load = 1'b0;

    // reset mid-scan at cur=6 with load high
    mode = 1'b1;
    for (int n = 0; n < 64 && m_cur[0] != 6; n++) step();
    chk("at_cur6", {29'd0, cur_a}, 32'd6);
    reset = 1'b1; load = 1'b1; sel = 3'd3;
    step();
    chk("midrst_out_a", {24'd0, out_a}, 32'h00);
    chk("midrst_out_b", {24'd0, out_b}, 32'hFF);
    chk("midrst_cur_a", {29'd0, cur_a}, 32'd0);
    reset = 1'b0; load = 1'b0;
    step();
    chk("post_rst_scan", {24'd0, out_a}, 32'h01);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 40) == 0);
      en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      load  = $urandom_range(0, 1) == 1;
      sel   = 3'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
